// File: rtl/snn_pkg.sv
// Shared SNN definitions: default field widths, the spike event layout and
// the head-register state of the event FIFO.
package snn_pkg;

    localparam int DEF_TS_WIDTH  = 16;
    localparam int DEF_NEURON_NO = 2**8;
    localparam int DEF_ADDR_W    = $clog2(DEF_NEURON_NO);
    localparam int DEF_EV_W      = DEF_TS_WIDTH + DEF_ADDR_W;

    typedef struct packed {
        logic [DEF_TS_WIDTH-1:0] ts;
        logic [DEF_ADDR_W-1:0]   addr;
    } spike_event_t;

    typedef enum logic {
        EMPTY     = 1'b0,
        HAVE_HEAD = 1'b1
    } head_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH event storage: one write port and a registered read port.
// A read of the word being written in the same cycle returns the new data.
module sync_fifo_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/spike_event_fifo.sv
// Spike event FIFO with registered first-word-fall-through output, level, full
// and sticky overflow. Define SPK_FIFO_DROP_CNT_EN to add the drop_cnt output.
module spike_event_fifo
    import snn_pkg::*;
#(
    parameter int NEURON_NO = DEF_NEURON_NO,
    parameter int TS_WIDTH  = DEF_TS_WIDTH,
    parameter int DEPTH     = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   sys_en,
    input  logic                                   flush,
    input  logic                                   in_valid,
    input  logic [TS_WIDTH+$clog2(NEURON_NO)-1:0]  in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [TS_WIDTH+$clog2(NEURON_NO)-1:0]  out_data,
    output logic [$clog2(DEPTH):0]                 level,
    output logic                                   full,
    output logic                                   ovf,
`ifdef SPK_FIFO_DROP_CNT_EN
    output logic [15:0]                            drop_cnt,
`endif
    input  logic                                   ovf_clr
);

    localparam int EV_W = TS_WIDTH + $clog2(NEURON_NO);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    head_state_t   head_q, head_nxt;
    logic          push_req, push, pop, overflow;

    // Pointers carry a wrap bit, so their difference is the occupancy 0..DEPTH.
    assign level     = wr_ptr - rd_ptr;
    assign full      = level[AW];
    assign out_valid = (head_q == HAVE_HEAD);

    assign push_req  = in_valid & sys_en & ~flush;
    assign pop       = out_valid & out_ready;
    assign overflow  = push_req & full & ~pop;
    assign push      = push_req & ~overflow;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        head_nxt   = head_q;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            head_nxt   = EMPTY;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
            case (head_q)
                EMPTY:     if (push) head_nxt = HAVE_HEAD;
                HAVE_HEAD: if (pop && !push && level == PW'(1)) head_nxt = EMPTY;
                default:   head_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= EMPTY;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            head_q <= head_nxt;
        end
    end

    // The RAM read register is the output register: it loads the next head
    // whenever the head can change, with bypass for a push into the head slot.
    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .re    (push | pop),
        .raddr (rd_ptr_nxt[AW-1:0]),
        .rdata (out_data)
    );

    // Set wins over clear so a coincident new overflow is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (overflow) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef SPK_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            drop_cnt <= overflow ? 16'd1 : 16'd0;
        end else if (overflow && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spike_event_fifo.sv
// Randomized self-checking bench for spike_event_fifo against a queue model.
// Honours SPK_FIFO_DROP_CNT_EN when the design is built with it.
module tb_spike_event_fifo;
    import snn_pkg::*;

    localparam int DEPTH = 64;
    localparam int EV_W  = DEF_EV_W;

    logic            clk;
    logic            reset;
    logic            sys_en;
    logic            flush;
    logic            in_valid;
    logic [EV_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [EV_W-1:0] out_data;
    logic [6:0]      level;
    logic            full;
    logic            ovf;
    logic            ovf_clr;
`ifdef SPK_FIFO_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    spike_event_fifo #(
        .NEURON_NO (DEF_NEURON_NO),
        .TS_WIDTH  (DEF_TS_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sys_en    (sys_en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .ovf       (ovf),
`ifdef SPK_FIFO_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: ordered queue of stored events plus loss bookkeeping.
    logic [EV_W-1:0] q[$];
    bit              m_ovf = 1'b0;
    int              m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [EV_W-1:0] ev(input logic [DEF_TS_WIDTH-1:0] ts,
                                           input logic [DEF_ADDR_W-1:0] addr);
        spike_event_t e;
        e.ts   = ts;
        e.addr = addr;
        return e;
    endfunction

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
        check("level", 32'(level), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef SPK_FIFO_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance the
    // model by the rules of one rising edge, then compare on the next falling edge.
    task automatic step(input bit iv, input logic [EV_W-1:0] d, input bit en,
                        input bit fl, input bit rdy, input bit clr);
        bit m_pop, m_push, m_drop;
        in_valid  = iv;
        in_data   = d;
        sys_en    = en;
        flush     = fl;
        out_ready = rdy;
        ovf_clr   = clr;
        m_pop  = (q.size() != 0) && rdy;
        m_push = iv && en && !fl;
        m_drop = m_push && (q.size() == DEPTH) && !m_pop;
        if (fl) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push && !m_drop) q.push_back(d);
        end
        if (m_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_cnt = m_drop ? 1 : 0;
        else if (m_drop && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(input logic [EV_W-1:0] d, input bit rdy);
        step(1'b1, d, 1'b1, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy, input bit clr);
        step(1'b0, '0, 1'b1, 1'b0, rdy, clr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_level"}, 32'(level),     32'd0);
        check({tag, "_full"},  32'(full),      32'd0);
        check({tag, "_ovf"},   32'(ovf),       32'd0);
`ifdef SPK_FIFO_DROP_CNT_EN
        check({tag, "_cnt"},   32'(drop_cnt),  32'd0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        sys_en    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state, then reset asserted mid-burst at level 5.
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) push(EV_W'($urandom()), 1'b0);
        reset = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        check_all_zero("reset_mid");
        @(negedge clk);
        reset = 1'b1;
        push(24'h001234, 1'b0);
        check("first_push_data", 32'(out_data), 32'h001234);

        // Fill to 64, overflow with 0xFFFFFF, clear ovf, then replace-at-full.
        for (int i = 1; i < DEPTH; i++) push(EV_W'($urandom()), 1'b0);
        push(24'hFFFFFF, 1'b0);
        check("ovf_after_drop", 32'(ovf), 32'd1);
        idle(1'b0, 1'b1);
        push(24'hAAAA01, 1'b1);
        check("replace_level", 32'(level), 32'(DEPTH));
        check("replace_no_ovf", 32'(ovf), 32'd0);
        drain();

        // Continuous pushes of addresses 0..255 at ts=7 against ready 1010...
        for (int i = 0; i < 256; i++) push(ev(16'd7, DEF_ADDR_W'(i)), (i % 2) == 0);
        drain();
        idle(1'b0, 1'b1);

        // Flush at level 10 with a coincident push; that event must vanish.
        for (int i = 0; i < 10; i++) push(EV_W'($urandom()), 1'b0);
        step(1'b1, 24'hBEEF55, 1'b1, 1'b1, 1'b0, 1'b0);
        push(24'h000777, 1'b0);
        drain();

        // sys_en low suppresses pushes without counting drops.
        for (int i = 0; i < 20; i++) step(1'b1, EV_W'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0);

        // ovf_clr coincident with a fresh overflow: ovf stays set, count restarts at 1.
        for (int i = 0; i < DEPTH + 2; i++) push(EV_W'($urandom()), 1'b0);
        step(1'b1, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_set_ovf", 32'(ovf), 32'd1);
        drain();

        // Random traffic with alternating drain-heavy and fill-heavy phases.
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 250; i++) begin
                step($urandom_range(0, 3) != 0,
                     EV_W'($urandom()),
                     $urandom_range(0, 7) != 0,
                     $urandom_range(0, 63) == 0,
                     (blk % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                     $urandom_range(0, 31) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
